// File: rtl/control_unit.sv
// K&S processor control unit: multi-cycle Moore sequencer for the data path.
// Also hosts the instruction decode type shared with data_path.
//
// state        | meaning
// -------------+-------------------------------------------------------
// FETCH_ADDR   | PC presented to RAM address register
// FETCH_WAIT   | RAM read latency
// FETCH_LOAD   | IR <= mem[PC], PC <= PC+1
// DECODE       | select execute path; retire count bumps (except HALT)
// LD_ADDR      | operand address to RAM
// LD_WAIT      | RAM read latency
// LD_WB        | register <= RAM data
// ST_ADDR      | operand address to RAM
// ST_WR        | single-cycle RAM write
// MOVE         | register copy through ALU (OR), flags untouched
// ALU          | ADD/SUB/AND/OR with flag update
// JUMP         | PC <= branch target
// HALTED       | stopped until reset

package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNEG   = 4'd10,
    I_HALT   = 4'd11
  } decoded_instruction_type;
endpackage

module control_unit
  import k_and_s_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic [CNT_W-1:0]        instr_count
);

  typedef enum logic [3:0] {
    S_FETCH_ADDR,
    S_FETCH_WAIT,
    S_FETCH_LOAD,
    S_DECODE,
    S_LD_ADDR,
    S_LD_WAIT,
    S_LD_WB,
    S_ST_ADDR,
    S_ST_WR,
    S_MOVE,
    S_ALU,
    S_JUMP,
    S_HALTED
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_instr_count;
  logic             w_retire;
  logic             w_unused_flags;

  // Overflow flags do not steer sequencing; they exist only for port symmetry.
  assign w_unused_flags = unsigned_overflow ^ signed_overflow;

  assign w_retire    = (r_state == S_DECODE) && (decoded_instruction != I_HALT);
  assign instr_count = r_instr_count;

  // State register; reset lands in FETCH_ADDR whose outputs are all zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH_ADDR;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Retired-instruction counter, frozen while halted, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_count <= '0;
    end else if (w_retire) begin
      r_instr_count <= r_instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Next-state selection and Moore output decode.
  always_comb begin
    w_next_state     = S_FETCH_ADDR;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = 2'b00;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    case (r_state)
      S_FETCH_ADDR: w_next_state = S_FETCH_WAIT;
      S_FETCH_WAIT: w_next_state = S_FETCH_LOAD;
      S_FETCH_LOAD: begin
        ir_enable    = 1'b1;
        pc_enable    = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        case (decoded_instruction)
          I_LOAD:                     w_next_state = S_LD_ADDR;
          I_STORE:                    w_next_state = S_ST_ADDR;
          I_MOVE:                     w_next_state = S_MOVE;
          I_ADD, I_SUB, I_AND, I_OR:  w_next_state = S_ALU;
          I_BRANCH:                   w_next_state = S_JUMP;
          I_BZERO:  w_next_state = zero_op ? S_JUMP : S_FETCH_ADDR;
          I_BNEG:   w_next_state = neg_op  ? S_JUMP : S_FETCH_ADDR;
          I_HALT:                     w_next_state = S_HALTED;
          default:                    w_next_state = S_FETCH_ADDR;
        endcase
      end
      S_LD_ADDR: begin
        addr_sel     = 1'b1;
        w_next_state = S_LD_WAIT;
      end
      S_LD_WAIT: begin
        addr_sel     = 1'b1;
        w_next_state = S_LD_WB;
      end
      S_LD_WB: begin
        addr_sel         = 1'b1;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
      end
      S_ST_ADDR: begin
        addr_sel     = 1'b1;
        w_next_state = S_ST_WR;
      end
      S_ST_WR: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
      end
      S_MOVE: write_reg_enable = 1'b1;
      S_ALU: begin
        write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1;
        case (decoded_instruction)
          I_ADD:   operation = 2'b01;
          I_SUB:   operation = 2'b10;
          I_AND:   operation = 2'b11;
          default: operation = 2'b00;
        endcase
      end
      S_JUMP: begin
        pc_enable = 1'b1;
        branch    = 1'b1;
      end
      S_HALTED: begin
        halt         = 1'b1;
        w_next_state = S_HALTED;
      end
      default: w_next_state = S_FETCH_ADDR;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle output vectors per instruction.
module tb_control_unit;
  import k_and_s_pkg::*;

  logic                    clk;
  logic                    rst_n;
  decoded_instruction_type decoded_instruction;
  logic                    zero_op;
  logic                    neg_op;
  logic                    unsigned_overflow;
  logic                    signed_overflow;
  logic                    branch;
  logic                    pc_enable;
  logic                    ir_enable;
  logic                    addr_sel;
  logic                    c_sel;
  logic [1:0]              operation;
  logic                    write_reg_enable;
  logic                    flags_reg_enable;
  logic                    ram_write_enable;
  logic                    halt;
  logic [15:0]             instr_count;

  control_unit #(.CNT_W(16)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .decoded_instruction (decoded_instruction),
    .zero_op             (zero_op),
    .neg_op              (neg_op),
    .unsigned_overflow   (unsigned_overflow),
    .signed_overflow     (signed_overflow),
    .branch              (branch),
    .pc_enable           (pc_enable),
    .ir_enable           (ir_enable),
    .addr_sel            (addr_sel),
    .c_sel               (c_sel),
    .operation           (operation),
    .write_reg_enable    (write_reg_enable),
    .flags_reg_enable    (flags_reg_enable),
    .ram_write_enable    (ram_write_enable),
    .halt                (halt),
    .instr_count         (instr_count)
  );

  // {branch, pc_en, ir_en, addr_sel, c_sel, op[1:0], wre, fre, rwe, halt}
  logic [10:0] w_outs;
  assign w_outs = {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
                   write_reg_enable, flags_reg_enable, ram_write_enable, halt};

  localparam logic [10:0] V_FETCH = 11'h300;

  int          total;
  int          bad;
  logic [15:0] exp_count;
  logic [10:0] obs   [0:31];
  logic [10:0] exp_v [0:31];
  int          exp_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle outputs from FETCH_LOAD to the next FETCH_LOAD.
  task automatic build_exp(input decoded_instruction_type ins, input logic z, input logic n);
    int body;
    body     = 0;
    exp_v[0] = V_FETCH;
    exp_v[1] = 11'h000;
    case (ins)
      I_LOAD:   begin exp_v[2] = 11'h080; exp_v[3] = 11'h080; exp_v[4] = 11'h0C8; body = 3; end
      I_STORE:  begin exp_v[2] = 11'h080; exp_v[3] = 11'h082; body = 2; end
      I_MOVE:   begin exp_v[2] = 11'h008; body = 1; end
      I_ADD:    begin exp_v[2] = 11'h01C; body = 1; end
      I_SUB:    begin exp_v[2] = 11'h02C; body = 1; end
      I_AND:    begin exp_v[2] = 11'h03C; body = 1; end
      I_OR:     begin exp_v[2] = 11'h00C; body = 1; end
      I_BRANCH: begin exp_v[2] = 11'h600; body = 1; end
      I_BZERO:  if (z) begin exp_v[2] = 11'h600; body = 1; end
      I_BNEG:   if (n) begin exp_v[2] = 11'h600; body = 1; end
      default:  body = 0;
    endcase
    exp_v[2+body] = 11'h000;
    exp_v[3+body] = 11'h000;
    exp_v[4+body] = V_FETCH;
    exp_n = 4 + body;
  endtask

  // Entered while the DUT sits in FETCH_LOAD; records obs[0..n].
  task automatic capture(input int n);
    obs[0] = w_outs;
    for (int i = 1; i <= n; i++) begin
      step();
      obs[i] = w_outs;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    decoded_instruction = I_NOP;
    zero_op = 1'b0; neg_op = 1'b0;
    unsigned_overflow = 1'b1; signed_overflow = 1'b1;
    exp_count = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (w_outs !== 11'h000 || instr_count !== 16'd0) begin
        bad++;
        $display("FAIL reset_hold cyc %0d: outs=%h cnt=%0d want outs=000 cnt=0", i, w_outs, instr_count);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 1; i <= 3; i++) begin
      total++;
      if (w_outs !== ((i == 3) ? V_FETCH : 11'h000) || instr_count !== 16'd0) begin
        bad++;
        $display("FAIL reset_release cyc %0d: outs=%h cnt=%0d want outs=%h cnt=0",
                 i, w_outs, instr_count, (i == 3) ? V_FETCH : 11'h000);
      end
      if (i < 3) step();
    end
  endtask

  task automatic test_add_nop;
    decoded_instruction_type prog [2];
    logic [15:0] start;
    prog  = '{I_ADD, I_NOP};
    start = exp_count;
    for (int k = 0; k < 2; k++) begin
      decoded_instruction = prog[k];
      build_exp(prog[k], 1'b0, 1'b0);
      capture(exp_n);
      exp_count++;
      for (int i = 0; i <= exp_n; i++) begin
        total++;
        if (obs[i] !== exp_v[i]) begin
          bad++;
          $display("FAIL add_nop %s cyc %0d: got %h want %h", prog[k].name(), i, obs[i], exp_v[i]);
        end
      end
    end
    total++;
    if (instr_count !== start + 16'd2) begin
      bad++;
      $display("FAIL add_nop_count: got %0d want %0d", instr_count, start + 16'd2);
    end
  endtask

  task automatic test_alu_ops;
    decoded_instruction_type prog [4];
    prog = '{I_SUB, I_AND, I_OR, I_MOVE};
    for (int k = 0; k < 4; k++) begin
      decoded_instruction = prog[k];
      build_exp(prog[k], 1'b0, 1'b0);
      capture(exp_n);
      exp_count++;
      for (int i = 0; i <= exp_n; i++) begin
        total++;
        if (obs[i] !== exp_v[i]) begin
          bad++;
          $display("FAIL alu_ops %s cyc %0d: got %h want %h", prog[k].name(), i, obs[i], exp_v[i]);
        end
      end
      total++;
      if (instr_count !== exp_count) begin
        bad++;
        $display("FAIL alu_ops_count %s: got %0d want %0d", prog[k].name(), instr_count, exp_count);
      end
    end
  endtask

  task automatic test_load;
    decoded_instruction = I_LOAD;
    build_exp(I_LOAD, 1'b0, 1'b0);
    capture(exp_n);
    exp_count++;
    for (int i = 0; i <= exp_n; i++) begin
      total++;
      if (obs[i] !== exp_v[i]) begin
        bad++;
        $display("FAIL load cyc %0d: got %h want %h", i, obs[i], exp_v[i]);
      end
    end
    total++;
    if (instr_count !== exp_count) begin
      bad++;
      $display("FAIL load_count: got %0d want %0d", instr_count, exp_count);
    end
  endtask

  task automatic test_store;
    decoded_instruction = I_STORE;
    build_exp(I_STORE, 1'b0, 1'b0);
    capture(exp_n);
    exp_count++;
    for (int i = 0; i <= exp_n; i++) begin
      total++;
      if (obs[i] !== exp_v[i]) begin
        bad++;
        $display("FAIL store cyc %0d: got %h want %h", i, obs[i], exp_v[i]);
      end
    end
    total++;
    if (instr_count !== exp_count) begin
      bad++;
      $display("FAIL store_count: got %0d want %0d", instr_count, exp_count);
    end
  endtask

  task automatic test_branches;
    decoded_instruction_type ins [6];
    logic zs [6];
    logic ns [6];
    ins = '{I_BZERO, I_BZERO, I_BNEG, I_BNEG, I_BRANCH, I_NOP};
    zs  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    ns  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 6; k++) begin
      decoded_instruction = ins[k];
      zero_op = zs[k];
      neg_op  = ns[k];
      build_exp(ins[k], zs[k], ns[k]);
      capture(exp_n);
      exp_count++;
      for (int i = 0; i <= exp_n; i++) begin
        total++;
        if (obs[i] !== exp_v[i]) begin
          bad++;
          $display("FAIL branch case %0d %s z=%b n=%b cyc %0d: got %h want %h",
                   k, ins[k].name(), zs[k], ns[k], i, obs[i], exp_v[i]);
        end
      end
      total++;
      if (instr_count !== exp_count) begin
        bad++;
        $display("FAIL branch_count case %0d: got %0d want %0d", k, instr_count, exp_count);
      end
    end
    zero_op = 1'b0;
    neg_op  = 1'b0;
  endtask

  task automatic test_halt_reset;
    decoded_instruction = I_HALT;
    step();
    total++;
    if (w_outs !== 11'h000) begin
      bad++;
      $display("FAIL halt_decode: got %h want 000", w_outs);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (w_outs !== 11'h001 || instr_count !== exp_count) begin
        bad++;
        $display("FAIL halt_hold cyc %0d: outs=%h cnt=%0d want outs=001 cnt=%0d",
                 i, w_outs, instr_count, exp_count);
      end
    end
    decoded_instruction = I_NOP;
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (halt !== 1'b0 || w_outs !== 11'h000 || instr_count !== 16'd0) begin
      bad++;
      $display("FAIL halt_async_reset: halt=%b outs=%h cnt=%0d want halt=0 outs=000 cnt=0",
               halt, w_outs, instr_count);
    end
    exp_count = '0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    total++;
    if (w_outs !== V_FETCH) begin
      bad++;
      $display("FAIL halt_restart_fetch: got %h want %h", w_outs, V_FETCH);
    end
    decoded_instruction = I_NOP;
    build_exp(I_NOP, 1'b0, 1'b0);
    capture(exp_n);
    exp_count++;
    total++;
    if (instr_count !== exp_count || obs[exp_n] !== V_FETCH) begin
      bad++;
      $display("FAIL halt_restart_nop: cnt=%0d outs=%h want cnt=%0d outs=%h",
               instr_count, obs[exp_n], exp_count, V_FETCH);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add_nop();
    test_alu_ops();
    test_load();
    test_store();
    test_branches();
    test_halt_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle Moore FSM that drives the K&S processor data path. It sequences fetch, decode and execute for every instruction in k_and_s_pkg.
- Consumes `decoded_instruction` and the registered flags from the data path.
- Produces every data-path control strobe plus the RAM write strobe.
- Sits beside data_path inside the processor top. Together they form the complete CPU.

Parameters:
- CNT_W, 16, width of the retired-instruction counter `instr_count`.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous reset, active-low
- decoded_instruction  input  decoded_instruction_type  current IR decode from data path
- zero_op  input  1  registered zero flag
- neg_op  input  1  registered negative flag
- unsigned_overflow  input  1  registered unsigned overflow flag (unused by sequencing; kept for interface symmetry)
- signed_overflow  input  1  registered signed overflow flag (unused by sequencing)
- branch  output  1  PC load select: 1 = branch target, 0 = PC+1
- pc_enable  output  1  PC update strobe
- ir_enable  output  1  IR load strobe
- addr_sel  output  1  RAM address select: 1 = instruction address field, 0 = PC
- c_sel  output  1  register write-back select: 1 = RAM data_in, 0 = ALU
- operation  output  2  ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
- write_reg_enable  output  1  register file write strobe
- flags_reg_enable  output  1  flag register update strobe
- ram_write_enable  output  1  RAM write strobe; data is data_out, address is ram_addr
- halt  output  1  processor halted
- instr_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset and interface:
  - Clock `clk`; asynchronous active-low reset `rst_n`.
  - Asserting `rst_n` low at any time, including mid-instruction, forces state FETCH_ADDR and clears `instr_count` to 0.
  - During reset all outputs are 0.
- Output decoding:
  - All strobes are decoded purely from the current state (Moore).
  - Any strobe not listed for a state is 0 in that state.
  - `operation` is 00 unless stated otherwise.
- States and transitions:
  - FETCH_ADDR: addr_sel=0 (the registered ram_addr captures PC). Next: FETCH_WAIT.
  - FETCH_WAIT: addr_sel=0; RAM read latency. Next: FETCH_LOAD.
  - FETCH_LOAD: ir_enable=1, pc_enable=1, branch=0 (IR<=mem[PC], PC<=PC+1). Next: DECODE.
  - DECODE: no strobes. Next state depends on `decoded_instruction`:
    - LOAD→LD_ADDR
    - STORE→ST_ADDR
    - MOVE→MOVE
    - ADD/SUB/AND/OR→ALU
    - BRANCH→JUMP
    - BZERO→JUMP if zero_op=1, else FETCH_ADDR
    - BNEG→JUMP if neg_op=1, else FETCH_ADDR
    - HALT→HALTED
    - NOP and any other value→FETCH_ADDR
  - `instr_count` increments by 1 on leaving DECODE for every instruction except HALT.
  - LD_ADDR: addr_sel=1. Next: LD_WAIT.
  - LD_WAIT: addr_sel=1. Next: LD_WB.
  - LD_WB: addr_sel=1, c_sel=1, write_reg_enable=1. Next: FETCH_ADDR.
  - ST_ADDR: addr_sel=1. Next: ST_WR.
  - ST_WR: addr_sel=1, ram_write_enable=1 (exactly one cycle). Next: FETCH_ADDR.
  - MOVE: operation=00, c_sel=0, write_reg_enable=1, flags_reg_enable=0. Next: FETCH_ADDR.
  - ALU: operation = ADD→01, SUB→10, AND→11, OR→00, taken from `decoded_instruction` sampled in this state. write_reg_enable=1, flags_reg_enable=1, c_sel=0. Next: FETCH_ADDR.
  - JUMP: pc_enable=1, branch=1. Next: FETCH_ADDR.
  - HALTED: halt=1, all other strobes 0. Self-loop until reset; `instr_count` frozen.
- Cycles per instruction (clock edges from entering FETCH_ADDR to re-entering it):
  - NOP, untaken BZERO/BNEG: 4
  - ALU, MOVE, taken branch: 5
  - STORE: 6
  - LOAD: 7
- Invariants:
  - pc_enable is never high in the same cycle as ram_write_enable.
  - branch=1 only when pc_enable=1.
  - write_reg_enable and ram_write_enable are never both high.
  - Flags consumed in DECODE are those registered by the last ALU instruction.
  - MOVE, LOAD and branches leave the flags untouched.

Test Plan:
- Reset with rst_n=0 for 3 cycles, release → all outputs 0 during reset; ir_enable=1 and pc_enable=1 exactly at cycle 3 after release; instr_count=0.
- Program ADD then NOP → in the ALU state operation=01, write_reg_enable=1, flags_reg_enable=1 for exactly 1 cycle; instr_count=2 after 9 cycles.
- LOAD → addr_sel=1 for 3 consecutive cycles; c_sel=1 with write_reg_enable=1 only in the 3rd cycle; next ir_enable 7 cycles after the previous one.
- STORE → ram_write_enable=1 for exactly 1 cycle, with addr_sel=1 and pc_enable=0.
- BZERO with zero_op=0, then again with zero_op=1 → first: no branch pulse, 4-cycle instruction; second: pc_enable=1 and branch=1 for 1 cycle, 5-cycle instruction. Repeat the pair for BNEG using neg_op.
- HALT, then pull rst_n low mid-HALTED → halt=1 stays held and instr_count is frozen for 20 cycles; on reset, halt falls to 0 asynchronously (before the next clock edge) and instr_count=0.
